// File: rtl/hls_infer_sequencer.sv
// hls_infer_sequencer: drives one hls4ml ap_ctrl_hs core.
// Per frame it:
//  - takes one feature vector over a valid/ready stream,
//  - launches the core and waits for ap_done,
//  - returns both layer outputs as a single valid/ready result beat.
// It also keeps a completed-frame counter and the launch-to-done latency of the last frame.
// Optional watchdog: define INFER_TIMEOUT_EN to abort a frame that runs TIMEOUT_CYC cycles.
//
// state  | meaning
// IDLE   | s_ready high, waiting for a feature vector
// LAUNCH | ap_start / input_1_ap_vld high until ap_ready is seen
// WAIT   | core running, waiting for ap_done
// HOLD   | result presented on m_*, waiting for m_ready
module hls_infer_sequencer #(
  parameter int IN_W        = 1800,
  parameter int OUT_W       = 24,
  parameter int LAT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               core_start,
  output logic [IN_W-1:0]    core_in,
  output logic               core_in_vld,
  input  logic               core_ready,
  input  logic               core_done,
  input  logic               core_idle,
  input  logic [OUT_W-1:0]   core_out0,
  input  logic [OUT_W-1:0]   core_out1,
  input  logic               core_out0_vld,
  input  logic               core_out1_vld,
  output logic [OUT_W-1:0]   m_out0,
  output logic [OUT_W-1:0]   m_out1,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [LAT_W-1:0]   last_latency,
  output logic               err_novld,
  output logic               err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t            state_q;
  logic [IN_W-1:0]   core_in_q;
  logic              core_start_q;
  logic              m_valid_q;
  logic              busy_q;
  logic [OUT_W-1:0]  m_out0_q;
  logic [OUT_W-1:0]  m_out1_q;
  logic              flag0_q;
  logic              flag1_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_d;
  logic [LAT_W-1:0]  last_latency_q;
  logic [15:0]       frame_cnt_q;
  logic              err_novld_q;
  logic              cap0;
  logic              cap1;
  logic              miss0;
  logic              miss1;

  // ap_idle is informational only; nothing in the sequencing depends on it.
  logic unused_core_idle;
  assign unused_core_idle = core_idle;

  // Saturating latency increment plus output-capture decisions for the current cycle.
  // An output with no vld pulse so far is taken from the bus on the done cycle
  // and flagged as missing.
  always_comb begin
    lat_cnt_d = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + 1'b1;
    cap0      = core_out0_vld || (core_done && !flag0_q);
    cap1      = core_out1_vld || (core_done && !flag1_q);
    miss0     = core_done && !flag0_q && !core_out0_vld;
    miss1     = core_done && !flag1_q && !core_out1_vld;
  end

`ifdef INFER_TIMEOUT_EN
  logic err_timeout_q;
  logic timeout_hit;

  // Watchdog fires on the last allowed cycle; a done on that same cycle takes priority.
  always_comb begin
    timeout_hit = (lat_cnt_q == LAT_W'(TIMEOUT_CYC - 1)) && !core_done;
  end

  assign err_timeout = err_timeout_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign err_timeout = 1'b0;
`endif

  // Main sequencer: state, registered handshake outputs, capture and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      core_in_q      <= '0;
      core_start_q   <= 1'b0;
      m_valid_q      <= 1'b0;
      busy_q         <= 1'b0;
      m_out0_q       <= '0;
      m_out1_q       <= '0;
      flag0_q        <= 1'b0;
      flag1_q        <= 1'b0;
      lat_cnt_q      <= '0;
      last_latency_q <= '0;
      frame_cnt_q    <= '0;
      err_novld_q    <= 1'b0;
`ifdef INFER_TIMEOUT_EN
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s_valid) begin
            core_in_q    <= s_data;
            lat_cnt_q    <= '0;
            flag0_q      <= 1'b0;
            flag1_q      <= 1'b0;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH, S_WAIT: begin
          lat_cnt_q <= lat_cnt_d;
          if (cap0) m_out0_q <= core_out0;
          if (cap1) m_out1_q <= core_out1;
          if (core_out0_vld) flag0_q <= 1'b1;
          if (core_out1_vld) flag1_q <= 1'b1;
          if (core_done) begin
            last_latency_q <= lat_cnt_q;
            if (miss0 || miss1) err_novld_q <= 1'b1;
            core_start_q   <= 1'b0;
            m_valid_q      <= 1'b1;
            state_q        <= S_HOLD;
`ifdef INFER_TIMEOUT_EN
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
`endif
          end else if (state_q == S_LAUNCH && core_ready) begin
            core_start_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (m_ready) begin
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready      = ~busy_q;
  assign core_start   = core_start_q;
  assign core_in_vld  = core_start_q;
  assign core_in      = core_in_q;
  assign m_out0       = m_out0_q;
  assign m_out1       = m_out1_q;
  assign m_valid      = m_valid_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign last_latency = last_latency_q;
  assign err_novld    = err_novld_q;

endmodule

// File: tb/tb_hls_infer_sequencer.sv
// Scoreboard bench for hls_infer_sequencer: directed frames push expected results,
// a monitor pops and compares on every m_valid & m_ready handshake.
module tb_hls_infer_sequencer;
  localparam int IN_W  = 1800;
  localparam int OUT_W = 24;
  localparam int LAT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              core_start;
  logic [IN_W-1:0]   core_in;
  logic              core_in_vld;
  logic              core_ready = 1'b0;
  logic              core_done = 1'b0;
  logic              core_idle = 1'b1;
  logic [OUT_W-1:0]  core_out0 = '0;
  logic [OUT_W-1:0]  core_out1 = '0;
  logic              core_out0_vld = 1'b0;
  logic              core_out1_vld = 1'b0;
  logic [OUT_W-1:0]  m_out0;
  logic [OUT_W-1:0]  m_out1;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [LAT_W-1:0]  last_latency;
  logic              err_novld;
  logic              err_timeout;

  hls_infer_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LAT_W(LAT_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_start(core_start), .core_in(core_in), .core_in_vld(core_in_vld),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_out0(core_out0), .core_out1(core_out1),
    .core_out0_vld(core_out0_vld), .core_out1_vld(core_out1_vld),
    .m_out0(m_out0), .m_out1(m_out1), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .last_latency(last_latency),
    .err_novld(err_novld), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] o0;
    logic [23:0] o1;
    logic [15:0] lat;
    logic [15:0] frame;
    logic        novld;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_frames = 0;
  logic exp_novld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] make_vec(input logic [7:0] seed);
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < 75; i++) v[i*24 +: 24] = {seed, 16'(i)};
    v[7:0] = 8'hA5;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    core_ready = 1'b0; core_done = 1'b0;
    core_out0_vld = 1'b0; core_out1_vld = 1'b0;
    core_out0 = '0; core_out1 = '0;
  endtask

  // Offer a vector and return in the launch cycle (lat_cnt == 0).
  task automatic send(input logic [IN_W-1:0] d);
    int n;
    s_data = d;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_wait: s_ready got 0 expected 1 within 50 cycles");
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [IN_W-1:0] d, input int rdy_at, input int done_at,
                           input int v0_at, input int v1_at,
                           input logic [23:0] o0, input logic [23:0] o1,
                           input logic [15:0] elat, input logic fnovld);
    exp_t e;
    send(d);
    chk("launch_start", 64'(core_start), 64'd1);
    chk("launch_in_vld", 64'(core_in_vld), 64'd1);
    chk("launch_core_in", 64'(core_in == d), 64'd1);
    chk("launch_s_ready", 64'(s_ready), 64'd0);
    for (int c = 0; c <= done_at; c++) begin
      core_ready    = (c == rdy_at);
      core_done     = (c == done_at);
      core_out0_vld = (c == v0_at);
      core_out1_vld = (c == v1_at);
      core_out0 = (c == v0_at || (c == done_at && !(v0_at >= 0 && v0_at < done_at)))
                  ? o0 : (24'hBAD000 | 24'(c));
      core_out1 = (c == v1_at || (c == done_at && !(v1_at >= 0 && v1_at < done_at)))
                  ? o1 : (24'hCAD000 | 24'(c));
      if (rdy_at >= 0 && c == rdy_at + 1) chk("wait_start_low", 64'(core_start), 64'd0);
      if (c == done_at) begin
        e.o0 = o0; e.o1 = o1; e.lat = elat;
        e.frame = 16'(exp_frames); e.novld = exp_novld | fnovld;
        sb.push_back(e);
        exp_novld = exp_novld | fnovld;
        exp_frames++;
      end
      tick();
    end
    clear_core();
    chk("hold_m_valid", 64'(m_valid), 64'd1);
  endtask

  task automatic finish_frame();
    tick();
    chk("post_s_ready", 64'(s_ready), 64'd1);
    chk("post_m_valid", 64'(m_valid), 64'd0);
    chk("post_frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
  endtask

  // Monitor: every accepted result beat must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got m_out0=%0h with no expectation", m_out0);
        end else begin
          e = sb.pop_front();
          chk("sb_m_out0", 64'(m_out0), 64'(e.o0));
          chk("sb_m_out1", 64'(m_out1), 64'(e.o1));
          chk("sb_latency", 64'(last_latency), 64'(e.lat));
          chk("sb_frame_cnt", 64'(frame_cnt), 64'(e.frame));
          chk("sb_err_novld", 64'(err_novld), 64'(e.novld));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    tick();

    // 1: ready at launch+2, done with both vld at launch+10
    run_frame(make_vec(8'h01), 2, 10, 10, 10, 24'h111111, 24'h222222, 16'd10, 1'b0);
    finish_frame();

    // 2: zero-latency core, 3-cycle turnaround
    run_frame(make_vec(8'h02), 0, 0, 0, 0, 24'h0A0A0A, 24'h0B0B0B, 16'd0, 1'b0);
    finish_frame();

    // 3: back-pressure in HOLD, stray done ignored
    m_ready = 1'b0;
    run_frame(make_vec(8'h03), 1, 5, 3, 5, 24'h333333, 24'h444444, 16'd5, 1'b0);
    s_data = make_vec(8'h09);
    s_valid = 1'b1;
    for (int h = 0; h < 20; h++) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_out0", 64'(m_out0), 64'h333333);
      chk("hold_out1", 64'(m_out1), 64'h444444);
      chk("hold_s_ready", 64'(s_ready), 64'd0);
      core_done = (h == 5); core_out0_vld = (h == 5); core_out1_vld = (h == 5);
      core_out0 = 24'hEEEEEE; core_out1 = 24'hFFFFFF;
      tick();
    end
    clear_core();
    s_valid = 1'b0;
    chk("hold_latency", 64'(last_latency), 64'd5);
    chk("hold_core_in", 64'(core_in == make_vec(8'h03)), 64'd1);
    m_ready = 1'b1;
    finish_frame();

`ifdef INFER_TIMEOUT_EN
    // watchdog abort after 16 cycles without done
    send(make_vec(8'h05));
    for (int c = 0; c < 16; c++) begin
      core_ready = (c == 1);
      if (c == 15) begin
        chk("to_busy_before", 64'(busy), 64'd1);
        chk("to_err_before", 64'(err_timeout), 64'd0);
      end
      tick();
    end
    clear_core();
    chk("to_err_timeout", 64'(err_timeout), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_m_valid", 64'(m_valid), 64'd0);
    chk("to_core_start", 64'(core_start), 64'd0);
    chk("to_s_ready", 64'(s_ready), 64'd1);
    chk("to_frame_cnt", 64'(frame_cnt), 64'd3);
    chk("to_last_latency", 64'(last_latency), 64'd5);
    tick();
    // done on the timeout cycle wins
    run_frame(make_vec(8'h06), 1, 15, 15, 15, 24'h565656, 24'h787878, 16'd15, 1'b0);
    finish_frame();
    chk("to_err_sticky", 64'(err_timeout), 64'd1);
`else
    // no watchdog: a 30-cycle frame completes normally
    run_frame(make_vec(8'h05), 1, 30, 30, 30, 24'h565656, 24'h787878, 16'd30, 1'b0);
    finish_frame();
    chk("nowd_err_timeout", 64'(err_timeout), 64'd0);
`endif

    // 4: out1 vld never pulsed
    run_frame(make_vec(8'h07), 0, 4, 2, -1, 24'h777777, 24'h888888, 16'd4, 1'b1);
    finish_frame();
    chk("novld_sticky", 64'(err_novld), 64'd1);

    // 5: reset while in WAIT
    send(make_vec(8'h08));
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    tick();
    tick();
    chk("wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_core_start", 64'(core_start), 64'd0);
    chk("mid_rst_core_in_vld", 64'(core_in_vld), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_latency", 64'(last_latency), 64'd0);
    chk("mid_rst_err_novld", 64'(err_novld), 64'd0);
    chk("mid_rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("mid_rst_core_in", 64'(core_in == '0), 64'd1);
    chk("mid_rst_m_out0", 64'(m_out0), 64'd0);
    chk("mid_rst_m_out1", 64'(m_out1), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
    exp_frames = 0;
    exp_novld = 1'b0;
    tick();

    run_frame(make_vec(8'h0A), 0, 2, 1, 2, 24'h121212, 24'h343434, 16'd2, 1'b0);
    finish_frame();

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
